multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, meaning opcode field width (min 4).
REQ-002 SHALL have parameter BRANCH_LO, default 1, meaning lowest branch opcode.
REQ-003 SHALL have parameter BRANCH_HI, default 5, meaning highest branch opcode.
REQ-004 SHALL have parameter JUMP_OP, default 6, meaning the jump opcode.
REQ-005 SHALL have parameter IMM_OP, default 7, meaning the immediate-ALU opcode.
REQ-006 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-008 SHALL have ports start (in, 1, leave IDLE) and opcode (in, OPCODE_W, instruction opcode, valid from DECODE).
REQ-009 SHALL have ports fetch_ack, mem_ack and branch_taken (each in, 1): fetch done, memory done, ALU condition true.
REQ-010 SHALL have ports fetch_req, ir_load, mem_req, mem_we, reg_we and pc_en (each out, 1): fetch strobe, IR capture, memory request, store, register write, PC advance.
REQ-011 SHALL have ports pc_sel_target, branch_en, jump_en and immediate_en (each out, 1): PC from target, plus the registered decode flags.
REQ-012 SHALL have ports illegal_op and busy (out, 1): sticky illegal-opcode flag, and not-IDLE.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB.
REQ-014 SHALL use opcode map: 0 NOP; BRANCH_LO..BRANCH_HI branch; JUMP_OP jump; IMM_OP immediate ALU; 8 load; 9 store; 10-13 register ALU; 15 HALT; 14 and any value >15 illegal.
REQ-015 IDLE: all strobes 0; start=1 -> FETCH next cycle and clears illegal_op.
REQ-016 FETCH: fetch_req=1 held until fetch_ack; ack cycle asserts ir_load for exactly 1 cycle, -> DECODE; no timeout.
REQ-017 DECODE: register branch_en/jump_en/immediate_en from opcode, held until next DECODE; illegal -> illegal_op=1, -> IDLE; HALT -> IDLE; else -> EXEC.
REQ-018 EXEC branch: pc_en=1, pc_sel_target=branch_taken (sampled this cycle), -> FETCH.
REQ-019 EXEC jump: pc_en=1, pc_sel_target=1, -> FETCH; NOP: pc_en=1, pc_sel_target=0, -> FETCH.
REQ-020 EXEC load/store -> MEM; EXEC immediate/register ALU -> WB.
REQ-021 MEM: mem_req=1 (mem_we=1 for store) held until mem_ack; store ack cycle: pc_en=1, -> FETCH; load ack -> WB.
REQ-022 WB: reg_we=1 and pc_en=1 for 1 cycle, -> FETCH.
REQ-023 Instruction latency SHALL be: NOP/branch/jump 3 cycles, ALU 4, store 4, load 5 (zero-wait acks, FETCH entry to next FETCH).
REQ-024 start while busy SHALL be ignored; fetch_ack/mem_ack outside FETCH/MEM SHALL be ignored.
REQ-025 Strobe outputs SHALL be combinational from state and inputs; decode flags and illegal_op SHALL be registered.

Reset
REQ-026 rst=1 SHALL force IDLE immediately, mid-instruction included; all outputs 0; illegal_op cleared; counter cleared.

Configuration
REQ-027 With CTRL_PERF_CNT_EN defined: extra output instr_count (32 bits) SHALL increment on every pc_en cycle, wrap 0xFFFFFFFF->0, and hold otherwise.
REQ-028 Without CTRL_PERF_CNT_EN: no port, no counter logic.

Structure
REQ-029 Package ctrl_pkg SHALL hold the state enum, opcode constants (NOP, LOAD, STORE, ALU_LO/HI, RSVD, HALT) and the instruction-class enum.
REQ-030 Sub-module ctrl_decode SHALL hold the combinational opcode->class decode; FSM, flags and counter live in the top.

Verification
REQ-031 rst, start, opcode=6, fetch_ack on 2nd FETCH cycle -> ir_load 1 cycle, pc_en=pc_sel_target=jump_en=1 in EXEC, back in FETCH.
REQ-032 opcode=3, branch_taken=0 then opcode=3, branch_taken=1 -> pc_sel_target 0 then 1; branch_en=1 both times.
REQ-033 opcode=8, mem_ack after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, reg_we 1 cycle in WB.
REQ-034 opcode=14 -> illegal_op=1, busy=0 next cycle; start -> illegal_op=0.
REQ-035 opcode=9 with rst asserted during MEM -> all outputs 0 at once, state IDLE.
REQ-036 CTRL_PERF_CNT_EN: instr_count preset to 0xFFFFFFFE, retire 2 NOPs -> 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multicycle control unit.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    localparam int OP_NOP    = 0;
    localparam int OP_LOAD   = 8;
    localparam int OP_STORE  = 9;
    localparam int OP_ALU_LO = 10;
    localparam int OP_ALU_HI = 13;
    localparam int OP_RSVD   = 14;
    localparam int OP_HALT   = 15;

    // Classes that retire straight out of EXEC without a MEM/WB phase.
    function automatic logic is_pc_class(input instr_class_e c);
        return (c == CLS_NOP) || (c == CLS_BRANCH) || (c == CLS_JUMP);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> instruction-class decode.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int BRANCH_LO = 1,
    parameter int BRANCH_HI = 5,
    parameter int JUMP_OP   = 6,
    parameter int IMM_OP    = 7
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output instr_class_e        cls_o
);

    localparam logic [OPCODE_W-1:0] V_NOP    = OPCODE_W'(OP_NOP);
    localparam logic [OPCODE_W-1:0] V_BR_LO  = OPCODE_W'(BRANCH_LO);
    localparam logic [OPCODE_W-1:0] V_BR_HI  = OPCODE_W'(BRANCH_HI);
    localparam logic [OPCODE_W-1:0] V_JUMP   = OPCODE_W'(JUMP_OP);
    localparam logic [OPCODE_W-1:0] V_IMM    = OPCODE_W'(IMM_OP);
    localparam logic [OPCODE_W-1:0] V_LOAD   = OPCODE_W'(OP_LOAD);
    localparam logic [OPCODE_W-1:0] V_STORE  = OPCODE_W'(OP_STORE);
    localparam logic [OPCODE_W-1:0] V_ALU_LO = OPCODE_W'(OP_ALU_LO);
    localparam logic [OPCODE_W-1:0] V_ALU_HI = OPCODE_W'(OP_ALU_HI);
    localparam logic [OPCODE_W-1:0] V_HALT   = OPCODE_W'(OP_HALT);

    // Anything not matched (the reserved code and every value above 15) is illegal.
    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (opcode_i == V_NOP)
            cls_o = CLS_NOP;
        else if (opcode_i >= V_BR_LO && opcode_i <= V_BR_HI)
            cls_o = CLS_BRANCH;
        else if (opcode_i == V_JUMP)
            cls_o = CLS_JUMP;
        else if (opcode_i == V_IMM)
            cls_o = CLS_IMM;
        else if (opcode_i == V_LOAD)
            cls_o = CLS_LOAD;
        else if (opcode_i == V_STORE)
            cls_o = CLS_STORE;
        else if (opcode_i >= V_ALU_LO && opcode_i <= V_ALU_HI)
            cls_o = CLS_ALU;
        else if (opcode_i == V_HALT)
            cls_o = CLS_HALT;
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB).
// Define CTRL_PERF_CNT_EN to add the retired-instruction counter output instr_count.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int BRANCH_LO = 1,
    parameter int BRANCH_HI = 5,
    parameter int JUMP_OP   = 6,
    parameter int IMM_OP    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                fetch_ack,
    input  logic                mem_ack,
    input  logic                branch_taken,
    output logic                fetch_req,
    output logic                ir_load,
    output logic                mem_req,
    output logic                mem_we,
    output logic                reg_we,
    output logic                pc_en,
    output logic                pc_sel_target,
    output logic                branch_en,
    output logic                jump_en,
    output logic                immediate_en,
    output logic                illegal_op,
    output logic                busy
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         instr_count
`endif
);

    state_e       state_q, state_d;
    instr_class_e cls_q, cls_d, dec_cls;
    logic         branch_en_q, branch_en_d;
    logic         jump_en_q, jump_en_d;
    logic         imm_en_q, imm_en_d;
    logic         illegal_q, illegal_d;

    ctrl_decode #(
        .OPCODE_W  (OPCODE_W),
        .BRANCH_LO (BRANCH_LO),
        .BRANCH_HI (BRANCH_HI),
        .JUMP_OP   (JUMP_OP),
        .IMM_OP    (IMM_OP)
    ) u_decode (
        .opcode_i (opcode),
        .cls_o    (dec_cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cls_q       <= CLS_NOP;
            branch_en_q <= 1'b0;
            jump_en_q   <= 1'b0;
            imm_en_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            branch_en_q <= branch_en_d;
            jump_en_q   <= jump_en_d;
            imm_en_q    <= imm_en_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        branch_en_d   = branch_en_q;
        jump_en_d     = jump_en_q;
        imm_en_d      = imm_en_q;
        illegal_d     = illegal_q;
        fetch_req     = 1'b0;
        ir_load       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_we        = 1'b0;
        pc_en         = 1'b0;
        pc_sel_target = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    illegal_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Flags follow every decode, including illegal/HALT (which clear them).
                cls_d       = dec_cls;
                branch_en_d = (dec_cls == CLS_BRANCH);
                jump_en_d   = (dec_cls == CLS_JUMP);
                imm_en_d    = (dec_cls == CLS_IMM);
                if (dec_cls == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (dec_cls == CLS_HALT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_pc_class(cls_q)) begin
                    pc_en         = 1'b1;
                    pc_sel_target = (cls_q == CLS_JUMP) ||
                                    ((cls_q == CLS_BRANCH) && branch_taken);
                    state_d       = ST_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_IMM || cls_q == CLS_ALU) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                if (mem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign branch_en    = branch_en_q;
    assign jump_en      = jump_en_q;
    assign immediate_en = imm_en_q;
    assign illegal_op   = illegal_q;
    assign busy         = (state_q != ST_IDLE);

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // Every pc_en cycle retires exactly one instruction; wraps naturally.
    assign instr_cnt_d = pc_en ? instr_cnt_q + 32'd1 : instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) instr_cnt_q <= '0;
        else     instr_cnt_q <= instr_cnt_d;
    end

    assign instr_count = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected output vectors
// are queued as stimulus is driven and compared at the following negedge.
module tb_multicycle_control_unit;

    localparam int OPCODE_W = 4;

    localparam logic [11:0] FR  = 12'h001;
    localparam logic [11:0] IR  = 12'h002;
    localparam logic [11:0] MR  = 12'h004;
    localparam logic [11:0] MW  = 12'h008;
    localparam logic [11:0] RW  = 12'h010;
    localparam logic [11:0] PC  = 12'h020;
    localparam logic [11:0] SEL = 12'h040;
    localparam logic [11:0] BR  = 12'h080;
    localparam logic [11:0] JMP = 12'h100;
    localparam logic [11:0] IMM = 12'h200;
    localparam logic [11:0] ILL = 12'h400;
    localparam logic [11:0] BSY = 12'h800;

    logic clk, rst, start, fetch_ack, mem_ack, branch_taken;
    logic [OPCODE_W-1:0] opcode;
    logic fetch_req, ir_load, mem_req, mem_we, reg_we, pc_en, pc_sel_target;
    logic branch_en, jump_en, immediate_en, illegal_op, busy;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count;
`endif
    logic [11:0] outv;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    multicycle_control_unit #(.OPCODE_W(OPCODE_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .opcode        (opcode),
        .fetch_ack     (fetch_ack),
        .mem_ack       (mem_ack),
        .branch_taken  (branch_taken),
        .fetch_req     (fetch_req),
        .ir_load       (ir_load),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .reg_we        (reg_we),
        .pc_en         (pc_en),
        .pc_sel_target (pc_sel_target),
        .branch_en     (branch_en),
        .jump_en       (jump_en),
        .immediate_en  (immediate_en),
        .illegal_op    (illegal_op),
        .busy          (busy)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    assign outv = {busy, illegal_op, immediate_en, jump_en, branch_en, pc_sel_target,
                   pc_en, reg_we, mem_we, mem_req, ir_load, fetch_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk(e.tag, {20'd0, outv}, e.exp);
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue the outputs expected for it.
    task automatic cyc(input string tag, input logic st, input logic [OPCODE_W-1:0] op,
                       input logic fa, input logic ma, input logic bt, input logic [11:0] exp);
        sb_t e;
        start        = st;
        opcode       = op;
        fetch_ack    = fa;
        mem_ack      = ma;
        branch_taken = bt;
        e.tag = tag;
        e.exp = {20'd0, exp};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0;
        fetch_ack = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst_hold", 1, 6, 1, 1, 1, 12'h000);
        cyc("rst_hold2", 0, 0, 0, 0, 0, 12'h000);
        rst = 1'b0;

        // jump, ack on the second FETCH cycle; stray start/acks must be ignored
        cyc("j_idle",  1, 6, 0, 0, 0, 12'h000);
        cyc("j_f0",    0, 6, 0, 0, 0, BSY|FR);
        cyc("j_f1",    1, 6, 1, 0, 0, BSY|FR|IR);
        cyc("j_dec",   0, 6, 0, 1, 0, BSY);
        cyc("j_exe",   0, 6, 1, 1, 0, BSY|JMP|SEL|PC);

        // branch not taken, then taken
        cyc("b0_f",    0, 3, 1, 0, 0, BSY|JMP|FR|IR);
        cyc("b0_dec",  0, 3, 0, 0, 1, BSY|JMP);
        cyc("b0_exe",  0, 3, 0, 0, 0, BSY|BR|PC);
        cyc("b1_f",    0, 3, 1, 0, 0, BSY|BR|FR|IR);
        cyc("b1_dec",  0, 3, 0, 0, 0, BSY|BR);
        cyc("b1_exe",  0, 3, 0, 0, 1, BSY|BR|SEL|PC);

        // load with three memory wait cycles
        cyc("ld_f",    0, 8, 1, 0, 0, BSY|BR|FR|IR);
        cyc("ld_dec",  0, 8, 0, 0, 0, BSY|BR);
        cyc("ld_exe",  0, 8, 0, 0, 0, BSY);
        for (int i = 0; i < 3; i++) cyc("ld_wait", 0, 8, 0, 0, 0, BSY|MR);
        cyc("ld_ack",  0, 8, 0, 1, 0, BSY|MR);
        cyc("ld_wb",   0, 8, 0, 1, 0, BSY|RW|PC);

        // immediate ALU and register ALU
        cyc("imm_f",   0, 7, 1, 0, 0, BSY|FR|IR);
        cyc("imm_dec", 0, 7, 0, 0, 0, BSY);
        cyc("imm_exe", 0, 7, 0, 0, 0, BSY|IMM);
        cyc("imm_wb",  0, 7, 0, 0, 0, BSY|IMM|RW|PC);
        cyc("alu_f",   0, 12, 1, 0, 0, BSY|IMM|FR|IR);
        cyc("alu_dec", 0, 12, 0, 0, 0, BSY|IMM);
        cyc("alu_exe", 0, 12, 0, 0, 0, BSY);
        cyc("alu_wb",  0, 12, 0, 0, 0, BSY|RW|PC);

        // zero-wait store, then NOP
        cyc("st_f",    0, 9, 1, 0, 0, BSY|FR|IR);
        cyc("st_dec",  0, 9, 0, 0, 0, BSY);
        cyc("st_exe",  0, 9, 0, 0, 0, BSY);
        cyc("st_mem",  0, 9, 0, 1, 0, BSY|MR|MW|PC);
        cyc("nop_f",   0, 0, 1, 0, 0, BSY|FR|IR);
        cyc("nop_dec", 0, 0, 0, 0, 0, BSY);
        cyc("nop_exe", 0, 0, 0, 0, 1, BSY|PC);

        // reserved opcode -> sticky illegal; start clears it; HALT returns to IDLE
        cyc("ill_f",     0, 14, 1, 0, 0, BSY|FR|IR);
        cyc("ill_dec",   0, 14, 0, 0, 0, BSY);
        cyc("ill_idle",  0, 0, 1, 1, 0, ILL);
        cyc("ill_start", 1, 0, 0, 0, 0, ILL);
        cyc("ill_clr",   0, 15, 1, 0, 0, BSY|FR|IR);
        cyc("halt_dec",  0, 15, 0, 0, 0, BSY);
        cyc("halt_idle", 0, 0, 1, 1, 0, 12'h000);

        // asynchronous reset in the middle of a store's MEM phase
        cyc("rs_idle", 1, 9, 0, 0, 0, 12'h000);
        cyc("rs_f",    0, 9, 1, 0, 0, BSY|FR|IR);
        cyc("rs_dec",  0, 9, 0, 0, 0, BSY);
        cyc("rs_exe",  0, 9, 0, 0, 0, BSY);
        cyc("rs_mem",  0, 9, 0, 0, 0, BSY|MR|MW);
        mem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rs_async", {20'd0, outv}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        cyc("rs_hold",  0, 9, 0, 1, 0, 12'h000);
        rst = 1'b0;
        cyc("rs_after", 0, 9, 1, 1, 0, 12'h000);

`ifdef CTRL_PERF_CNT_EN
        chk("cnt_rst", instr_count, 32'd0);
        force dut.instr_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.instr_cnt_q;
        cyc("c_idle",  1, 0, 0, 0, 0, 12'h000);
        for (int k = 0; k < 2; k++) begin
            cyc("c_f",   0, 0, 1, 0, 0, BSY|FR|IR);
            cyc("c_dec", 0, 0, 0, 0, 0, BSY);
            cyc("c_exe", 0, 0, 0, 0, 0, BSY|PC);
            chk(k == 0 ? "cnt_ffff" : "cnt_wrap", instr_count, k == 0 ? 32'hFFFF_FFFF : 32'h0);
        end
        cyc("c_hold",  0, 0, 0, 0, 0, BSY|FR);
        chk("cnt_hold", instr_count, 32'h0);
`endif

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
